// File: rtl/fmem_pkg.sv
// Shared types and helpers for the display-side frame-memory read path.
// The localparams give the default 320x240, 4-pixels-per-word layout.
package fmem_pkg;

    typedef struct packed {
        logic mirror_h;
        logic flip_v;
    } mode_t;

    localparam int unsigned FRAME_WORDS    = 320 * 240 / 4;
    localparam int unsigned WORDS_PER_LINE = 320 / 4;

    function automatic int unsigned bank_base(input int unsigned bank,
                                              input int unsigned frame_words);
        return bank * frame_words;
    endfunction

endpackage

// File: rtl/fmem_rd_ctrl_if.sv
// Single-port synchronous SRAM port of the frame memory, seen from the reader.
interface fmem_rd_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 96
);
    logic                  fmem_csn;
    logic                  fmem_wen;
    logic [ADDR_WIDTH-1:0] fmem_addr;
    logic [DATA_WIDTH-1:0] fmem_dout;

    modport master (output fmem_csn, output fmem_wen, output fmem_addr, input fmem_dout);
    modport slave  (input fmem_csn, input fmem_wen, input fmem_addr, output fmem_dout);
endinterface

// File: rtl/fmem_unpack.sv
// Splits a packed memory word into pixels: phase 0 straight from the SRAM,
// later phases from a hold register captured on the cycle after the read.
module fmem_unpack #(
    parameter int unsigned  PW  = 24,
    parameter int unsigned  PPW = 4,
    localparam int unsigned PhW = (PPW > 1) ? $clog2(PPW) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cap_i,
    input  logic [PhW-1:0]    phase_i,
    input  logic              mirror_i,
    input  logic [PW*PPW-1:0] dout_i,
    output logic [PW-1:0]     pixel_o
);
    logic [PW*PPW-1:0] hold_q;
    logic [PW*PPW-1:0] src;
    logic [PhW-1:0]    idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else if (cap_i) begin
            hold_q <= dout_i;
        end
    end

    always_comb begin
        src     = (phase_i == '0) ? dout_i : hold_q;
        idx     = mirror_i ? (PhW'(PPW - 1) - phase_i) : phase_i;
        pixel_o = src[32'(idx) * PW +: PW];
    end

endmodule

// File: rtl/fmem_rd_ctrl.sv
// Frame-memory read controller: follows display timing, fetches packed words
// and emits a pixel stream aligned with the syncs delayed by two cycles.
module fmem_rd_ctrl #(
    parameter int unsigned  HRES        = 320,
    parameter int unsigned  VRES        = 240,
    parameter int unsigned  PW          = 24,
    parameter int unsigned  PPW         = 4,
    parameter int unsigned  NUM_BANKS   = 1,
    parameter int unsigned  DATA_WIDTH  = PW * PPW,
    parameter int unsigned  FRAME_WORDS = HRES * VRES / PPW,
    parameter int unsigned  ADDR_WIDTH  = $clog2(FRAME_WORDS * NUM_BANKS),
    localparam int unsigned BankW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [BankW-1:0] i_bank,
    input  logic             i_mirror_h,
    input  logic             i_flip_v,
    fmem_rd_ctrl_if.master   fmem,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [PW-1:0]    o_pixel,
    output logic             o_err
);
    import fmem_pkg::mode_t;
    import fmem_pkg::bank_base;

    localparam int unsigned WordsPerLine = HRES / PPW;
    localparam int unsigned XW           = $clog2(HRES + 1) + 2;
    localparam int unsigned YW           = $clog2(VRES + 1) + 1;
    localparam int unsigned PhW          = (PPW > 1) ? $clog2(PPW) : 1;

    logic             vs1_q, hs1_q, de1_q, vs2_q, hs2_q, de2_q;
    logic             valid_q, err_q, err_d;
    mode_t            mode_q, mode_e;
    logic [BankW-1:0] bank_q, bank_e;
    logic [XW-1:0]    x_q, x_e, x_d;
    logic [YW-1:0]    y_q, y_e, y_d;
    logic             rd1_q, ok1_q, mir1_q;
    logic [PhW-1:0]   ph1_q, phase;
    logic [PW-1:0]    pix_q, unpack_pix;
    logic             fs, valid_e, pix_ok, rd_en;
    logic [31:0]      ly, wx, addr_full;

    // A vsync rise overrides the registered frame state in the same cycle so a
    // coincident de counts as pixel 0 of line 0 of the new frame.
    always_comb begin
        fs              = i_vsync & ~vs1_q;
        valid_e         = fs | valid_q;
        x_e             = fs ? '0 : x_q;
        y_e             = fs ? '0 : y_q;
        mode_e.mirror_h = fs ? i_mirror_h : mode_q.mirror_h;
        mode_e.flip_v   = fs ? i_flip_v : mode_q.flip_v;
        bank_e          = fs ? i_bank : bank_q;

        pix_ok = i_de & valid_e & (x_e < XW'(HRES)) & (y_e < YW'(VRES)) & ~rst;
        phase  = PhW'(32'(x_e) % PPW);
        rd_en  = pix_ok & (phase == '0);

        ly        = mode_e.flip_v ? (VRES - 1 - 32'(y_e)) : 32'(y_e);
        wx        = mode_e.mirror_h ? (WordsPerLine - 1 - 32'(x_e) / PPW) : (32'(x_e) / PPW);
        addr_full = bank_base(32'(bank_e), FRAME_WORDS) + ly * WordsPerLine + wx;

        fmem.fmem_csn  = ~rd_en;
        fmem.fmem_wen  = 1'b1;
        fmem.fmem_addr = rd_en ? addr_full[ADDR_WIDTH-1:0] : '0;
    end

    always_comb begin
        x_d   = x_e;
        y_d   = y_e;
        err_d = err_q;
        if (i_de) begin
            if (x_e != '1) x_d = x_e + 1'b1;
        end else if (de1_q && !fs) begin
            x_d = '0;
            if (y_e != '1) y_d = y_e + 1'b1;
        end

        if (i_de && valid_e && (x_e >= XW'(HRES))) err_d = 1'b1;
        if (i_de && !de1_q && valid_e && (y_e >= YW'(VRES))) err_d = 1'b1;
        if (!i_de && de1_q && valid_q && !fs && ((32'(x_q) % PPW) != 0)) err_d = 1'b1;
    end

    fmem_unpack #(
        .PW  (PW),
        .PPW (PPW)
    ) u_unpack (
        .clk_i    (i_clk),
        .rst_i    (rst),
        .cap_i    (rd1_q),
        .phase_i  (ph1_q),
        .mirror_i (mir1_q),
        .dout_i   (fmem.fmem_dout),
        .pixel_o  (unpack_pix)
    );

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            {vs1_q, hs1_q, de1_q, vs2_q, hs2_q, de2_q} <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= '0;
            bank_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rd1_q   <= 1'b0;
            ok1_q   <= 1'b0;
            mir1_q  <= 1'b0;
            ph1_q   <= '0;
            pix_q   <= '0;
        end else begin
            {vs1_q, hs1_q, de1_q} <= {i_vsync, i_hsync, i_de};
            {vs2_q, hs2_q, de2_q} <= {vs1_q, hs1_q, de1_q};
            valid_q <= valid_e;
            err_q   <= err_d;
            mode_q  <= mode_e;
            bank_q  <= bank_e;
            x_q     <= x_d;
            y_q     <= y_d;
            rd1_q   <= rd_en;
            ok1_q   <= pix_ok;
            mir1_q  <= mode_e.mirror_h;
            ph1_q   <= phase;
            pix_q   <= ok1_q ? unpack_pix : '0;
        end
    end

    assign o_vsync = vs2_q;
    assign o_hsync = hs2_q;
    assign o_de    = de2_q;
    assign o_pixel = pix_q;
    assign o_err   = err_q;

endmodule
